// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch-side, data-side and external-bus signals around the memory port arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory environment.
interface mem_port_arbiter_if;
  // Fetch side
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_err;
  logic        if_stall;
  // Data side
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        dm_err;
  logic        dm_stall;
  // External memory bus
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata,
           bus_gnt, bus_rvalid, bus_rdata,
    output if_rdata, if_valid, if_err, if_stall, dm_rdata, dm_valid, dm_err, dm_stall,
           bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata,
           bus_gnt, bus_rvalid, bus_rdata,
    input  if_rdata, if_valid, if_err, if_stall, dm_rdata, dm_valid, dm_err, dm_stall,
           bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and the data stage, one transaction at a time,
// with a cycle counter that aborts transactions whose grant or response never arrives.
module mem_port_arbiter #(
  parameter bit          DATA_FIRST     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8,
  parameter logic [31:0] FETCH_ERR_INST = 32'h0000_0013
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave io
);

  typedef enum logic [2:0] {StIdle, StReqI, StRespI, StReqD, StRespD} state_e;

  localparam bit             TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TimeoutEn ? TIMEOUT_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_we_q, bus_we_d;
  logic [3:0]       bus_wstrb_q, bus_wstrb_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic             if_valid_q, if_valid_d;
  logic             if_err_q, if_err_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic             dm_valid_q, dm_valid_d;
  logic             dm_err_q, dm_err_d;
  logic [31:0]      dm_rdata_q, dm_rdata_d;

  logic if_req_m, dm_req_m, timeout_hit, resp_done, bus_req;

  // A requester whose completion pulse is out this cycle still holds req; don't serve it twice.
  assign if_req_m    = io.if_req & ~if_valid_q;
  assign dm_req_m    = io.dm_req & ~dm_valid_q;
  assign timeout_hit = TimeoutEn && (cnt_q == CntLast);
  assign resp_done   = ((state_q == StRespI) || (state_q == StRespD)) && io.bus_rvalid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bus_we_q    <= 1'b0;
      bus_wstrb_q <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_valid_q  <= 1'b0;
      dm_err_q    <= 1'b0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_we_q    <= bus_we_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_valid_q  <= if_valid_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      dm_valid_q  <= dm_valid_d;
      dm_err_q    <= dm_err_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (dm_req_m && (DATA_FIRST || !if_req_m)) state_d = StReqD;
        else if (if_req_m)                         state_d = StReqI;
      end
      // Response in the grant cycle is ignored; the response must follow the grant.
      StReqI:  if (timeout_hit) state_d = StIdle; else if (io.bus_gnt) state_d = StRespI;
      StReqD:  if (timeout_hit) state_d = StIdle; else if (io.bus_gnt) state_d = StRespD;
      StRespI: if (io.bus_rvalid || timeout_hit) state_d = StIdle;
      StRespD: if (io.bus_rvalid || timeout_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    bus_we_d    = bus_we_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_valid_d  = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_valid_d  = 1'b0;
    dm_err_d    = 1'b0;
    dm_rdata_d  = dm_rdata_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
      if (state_d == StReqD) begin
        bus_we_d    = io.dm_we;
        bus_wstrb_d = io.dm_we ? io.dm_wstrb : 4'b0000;
        bus_addr_d  = io.dm_addr;
        bus_wdata_d = io.dm_wdata;
      end else if (state_d == StReqI) begin
        bus_we_d    = 1'b0;
        bus_wstrb_d = 4'b0000;
        bus_addr_d  = io.if_addr;
        bus_wdata_d = '0;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (state_d == StIdle) begin
        if ((state_q == StReqI) || (state_q == StRespI)) begin
          if_valid_d = 1'b1;
          if_err_d   = ~resp_done;
          if_rdata_d = resp_done ? io.bus_rdata : FETCH_ERR_INST;
        end else begin
          dm_valid_d = 1'b1;
          dm_err_d   = ~resp_done;
          dm_rdata_d = (resp_done && !bus_we_q) ? io.bus_rdata : 32'h0;
        end
      end
    end
  end

  always_comb begin
    bus_req = (state_q == StReqI) || (state_q == StReqD);
  end

  assign io.bus_req   = bus_req;
  assign io.bus_we    = bus_we_q;
  assign io.bus_wstrb = bus_wstrb_q;
  assign io.bus_addr  = bus_addr_q;
  assign io.bus_wdata = bus_wdata_q;
  assign io.if_valid  = if_valid_q;
  assign io.if_err    = if_err_q;
  assign io.if_rdata  = if_rdata_q;
  assign io.dm_valid  = dm_valid_q;
  assign io.dm_err    = dm_err_q;
  assign io.dm_rdata  = dm_rdata_q;
  // Stalls are combinational so the pipeline freezes in the same cycle it raises a request.
  assign io.if_stall  = io.if_req & ~if_valid_q;
  assign io.dm_stall  = io.dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized transactions, checked against a
// transaction-level model (arbitration order, latency arithmetic, timeout rule, word memory).
module tb_mem_port_arbiter;

  localparam int unsigned Timeout   = 8;
  localparam bit          DataFirst = 1'b1;
  localparam logic [31:0] FetchErr  = 32'h0000_0013;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          g;  // cycles the grant is withheld
    int          r;  // extra cycles before the response
  } req_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  // mem is the bus-side memory written from what the DUT drives; ref_mem is the model's view.
  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];

  mem_port_arbiter_if io ();

  mem_port_arbiter #(
    .DATA_FIRST    (DataFirst),
    .TIMEOUT_CYCLES(Timeout),
    .CNT_W         (8),
    .FETCH_ERR_INST(FetchErr)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (io)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] idx(input logic [31:0] a);
    return a[5:2];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] v;
    v = old;
    for (int b = 0; b < 4; b++) if (st[b]) v[8*b +: 8] = wd[8*b +: 8];
    return v;
  endfunction

  function automatic req_t mk(input bit is_d, input logic [31:0] addr, input bit we,
                              input logic [3:0] wstrb, input logic [31:0] wdata,
                              input int g, input int r);
    req_t q;
    q.is_d = is_d; q.addr = addr; q.we = we; q.wstrb = wstrb; q.wdata = wdata;
    q.g = g; q.r = r;
    return q;
  endfunction

  task automatic raise(input req_t q);
    if (q.is_d) begin
      io.dm_req = 1'b1; io.dm_we = q.we; io.dm_wstrb = q.wstrb;
      io.dm_addr = q.addr; io.dm_wdata = q.wdata;
    end else begin
      io.if_req = 1'b1; io.if_addr = q.addr;
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check(tag, {io.bus_req, io.bus_we, io.bus_wstrb, io.bus_addr, io.bus_wdata}, 72'h0);
    check(tag, {io.if_valid, io.if_err, io.dm_valid, io.dm_err, io.if_rdata, io.dm_rdata}, 72'h0);
  endtask

  // Entered at the first cycle the command should be on the bus; leaves at the completion cycle.
  task automatic txn(input req_t q);
    bit          abort;
    int          vcyc;
    logic [31:0] exp_rd;
    logic [3:0]  exp_st;
    bit          store;
    store  = q.is_d && q.we;
    abort  = (q.g + q.r + 2) > int'(Timeout);
    vcyc   = abort ? int'(Timeout) : q.g + q.r + 2;
    exp_st = store ? q.wstrb : 4'b0000;
    if (store) ref_mem[idx(q.addr)] = merge(ref_mem[idx(q.addr)], q.wdata, q.wstrb);
    check("stall_hi", q.is_d ? io.dm_stall : io.if_stall, 1'b1);
    for (int c = 0; c < vcyc; c++) begin
      if (c <= q.g) begin
        check("cmd", {io.bus_req, io.bus_we, io.bus_wstrb, io.bus_addr},
              {1'b1, store, exp_st, q.addr});
        if (store) check("wdata", io.bus_wdata, q.wdata);
        io.bus_gnt    = (c == q.g);
        io.bus_rvalid = 1'($urandom_range(0, 1));
        if (c == q.g && io.bus_we)
          mem[idx(io.bus_addr)] = merge(mem[idx(io.bus_addr)], io.bus_wdata, io.bus_wstrb);
      end else begin
        if (c == q.g + 1) check("req_drop", io.bus_req, 1'b0);
        io.bus_gnt    = 1'b0;
        io.bus_rvalid = !abort && (c == q.g + 1 + q.r);
        if (io.bus_rvalid && !io.bus_we) io.bus_rdata = mem[idx(io.bus_addr)];
        else                             io.bus_rdata = $urandom();
      end
      @(negedge clk);
    end
    io.bus_gnt    = 1'b0;
    io.bus_rvalid = 1'b0;
    if (abort) exp_rd = q.is_d ? 32'h0 : FetchErr;
    else       exp_rd = store ? 32'h0 : ref_mem[idx(q.addr)];
    if (q.is_d) begin
      check("dm_valid", io.dm_valid, 1'b1);
      check("dm_err", io.dm_err, abort);
      check("dm_rdata", io.dm_rdata, exp_rd);
      check("dm_stall_lo", io.dm_stall, 1'b0);
      check("if_valid_lo", io.if_valid, 1'b0);
    end else begin
      check("if_valid", io.if_valid, 1'b1);
      check("if_err", io.if_err, abort);
      check("if_rdata", io.if_rdata, exp_rd);
      check("if_stall_lo", io.if_stall, 1'b0);
      check("dm_valid_lo", io.dm_valid, 1'b0);
    end
  endtask

  // Drop the request one cycle after completion; the bus noise in the idle cycle must be ignored.
  task automatic finish(input bit is_d);
    @(negedge clk);
    if (is_d) io.dm_req = 1'b0; else io.if_req = 1'b0;
    check("pulse_end", is_d ? io.dm_valid : io.if_valid, 1'b0);
    check("no_reissue", io.bus_req, 1'b0);
    io.bus_gnt    = 1'b1;
    io.bus_rvalid = 1'b1;
    io.bus_rdata  = $urandom();
    @(negedge clk);
    io.bus_gnt    = 1'b0;
    io.bus_rvalid = 1'b0;
    check("idle_quiet", {io.bus_req, io.if_valid, io.dm_valid}, 3'b000);
  endtask

  task automatic single(input req_t q);
    raise(q);
    #1 check("stall_comb", q.is_d ? io.dm_stall : io.if_stall, 1'b1);
    @(negedge clk);
    txn(q);
    finish(q.is_d);
  endtask

  task automatic pair(input req_t qd, input req_t qf);
    req_t first, second;
    first  = DataFirst ? qd : qf;
    second = DataFirst ? qf : qd;
    raise(qd);
    raise(qf);
    #1 check("both_stall", {io.dm_stall, io.if_stall}, 2'b11);
    @(negedge clk);
    txn(first);
    @(negedge clk);
    if (first.is_d) io.dm_req = 1'b0; else io.if_req = 1'b0;
    check("first_pulse_end", first.is_d ? io.dm_valid : io.if_valid, 1'b0);
    txn(second);
    finish(second.is_d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_t q, qf;
    int   kind;
    reset = 1'b0;
    io.if_req = 1'b0; io.if_addr = '0;
    io.dm_req = 1'b0; io.dm_we = 1'b0; io.dm_wstrb = '0; io.dm_addr = '0; io.dm_wdata = '0;
    io.bus_gnt = 1'b0; io.bus_rvalid = 1'b0; io.bus_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = $urandom();
      ref_mem[i] = mem[i];
    end
    repeat (2) @(negedge clk);
    check_reset_outs("reset_state");
    reset = 1'b1;
    @(negedge clk);

    // Single fetch with minimum latency
    mem[0] = 32'h0000_0297; ref_mem[0] = 32'h0000_0297;
    single(mk(1'b0, 32'h8000_0000, 1'b0, 4'h0, 32'h0, 0, 0));

    // Simultaneous load and fetch: data wins, fetch issued right after
    pair(mk(1'b1, 32'h8000_1000, 1'b0, 4'hF, 32'h1234_5678, 0, 0),
         mk(1'b0, 32'h8000_0000, 1'b0, 4'h0, 32'h0, 0, 0));

    // Partial store, then read it back
    single(mk(1'b1, 32'h8000_1000, 1'b1, 4'b0011, 32'hDEAD_BEEF, 0, 0));
    single(mk(1'b1, 32'h8000_1000, 1'b0, 4'hF, 32'h0, 1, 2));

    // Grant withheld for 5 cycles
    single(mk(1'b0, 32'h8000_0008, 1'b0, 4'h0, 32'h0, 5, 0));

    // Fetch with no response: aborts, stray response afterwards ignored
    single(mk(1'b0, 32'h8000_0004, 1'b0, 4'h0, 32'h0, 0, 20));

    // Reset while a load waits for its response
    q = mk(1'b1, 32'h8000_100C, 1'b0, 4'h0, 32'h0, 0, 0);
    raise(q);
    @(negedge clk);
    check("rst_case_req", io.bus_req, 1'b1);
    io.bus_gnt = 1'b1;
    @(negedge clk);
    io.bus_gnt = 1'b0;
    reset = 1'b0;
    io.dm_req = 1'b0;
    #1 check_reset_outs("reset_mid_resp");
    @(negedge clk);
    reset = 1'b1;
    io.bus_rvalid = 1'b1;
    io.bus_rdata  = $urandom();
    @(negedge clk);
    io.bus_rvalid = 1'b0;
    check("late_rvalid", {io.bus_req, io.dm_valid, io.if_valid}, 3'b000);
    @(negedge clk);
    check("late_rvalid2", {io.bus_req, io.dm_valid, io.if_valid}, 3'b000);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      kind = int'($urandom_range(0, 2));
      qf = mk(1'b0, 32'h8000_0000 | ($urandom_range(0, 15) << 2), 1'b0, 4'h0, 32'h0,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      q  = mk(1'b1, 32'h8000_1000 | ($urandom_range(0, 15) << 2), 1'($urandom_range(0, 1)),
              4'($urandom()), $urandom(), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      case (kind)
        0:       single(qf);
        1:       single(q);
        default: pair(q, qf);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
